// File: rtl/scale_share_arb_if.sv
// Requester and consumer handshake bundle for scale_share_arb.
// The slave modport is the arbiter's view; master is the producer/consumer side.
interface scale_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [31:0]        out_data;
    logic [IDW-1:0]     out_id;
    logic               out_ready;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/scale_share_arb.sv
// Round-robin arbiter sharing one sign-magnitude constant scaler (a4) among NREQ requesters.
// state | meaning
// IDLE  | waiting for any req_valid; grants the round-robin winner
// CALC  | in_reg drives a4; result registered on the edge
// HOLD  | out_valid high, result held until out_ready
module scale_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    scale_share_arb_if.slave bus,
    output logic             busy,
    output logic [CNTW-1:0]  done_cnt
);
    // Bit k set means magnitude>>k contributes to the scaled sum.
    localparam logic [31:0] SHIFT_SET = 32'h8FE7_49CE;

    generate
        if (IDW < $clog2(NREQ) || NREQ < 2 || NREQ > 8) begin : g_bad_param
            $error("scale_share_arb: illegal NREQ/IDW combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  id_reg;
    logic [31:0]     in_reg;
    logic [31:0]     out_data;
    logic [IDW-1:0]  out_id;
    logic            out_valid;
    logic [IDW-1:0]  gnt;
    logic            found;
    logic [NREQ-1:0] req_ready;
    int              idx;

    function automatic logic [30:0] a4(input logic [30:0] m);
        logic [30:0] acc;
        acc = '0;
        for (int k = 1; k < 32; k++) begin
            if (SHIFT_SET[k]) acc = acc + (m >> k);
        end
        return acc;
    endfunction

    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[gnt] = 1'b1;
                    state_n        = CALC;
                end
            end
            CALC:    state_n = HOLD;
            HOLD:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_reg    <= '0;
            in_reg    <= '0;
            out_data  <= '0;
            out_id    <= '0;
            out_valid <= 1'b0;
            done_cnt  <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (found) begin
                        in_reg <= bus.req_data[32*gnt +: 32];
                        id_reg <= gnt;
                        rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
                    end
                end
                CALC: begin
                    out_data  <= {in_reg[31], a4(in_reg[30:0])};
                    out_id    <= id_reg;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // No grant may be offered while reset is held, even though state already reads IDLE.
    assign bus.req_ready = rst_n ? req_ready : '0;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_id    = out_id;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_scale_share_arb.sv
// Randomised and directed bench for scale_share_arb against a transaction-level model.
module tb_scale_share_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, busy_w;
    logic [15:0] done_cnt;
    logic [2:0]  done_cnt_w;
    int          total = 0;
    int          bad = 0;

    scale_share_arb_if #(.NREQ(4), .IDW(2)) bus ();
    scale_share_arb_if #(.NREQ(4), .IDW(2)) bus_w ();

    scale_share_arb #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done_cnt(done_cnt));

    // Narrow-counter copy so the wrap to zero is reachable in a short run.
    scale_share_arb #(.NREQ(4), .IDW(2), .CNTW(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w), .busy(busy_w), .done_cnt(done_cnt_w));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_scale(input logic [31:0] w);
        int     sh[19] = '{1, 2, 3, 6, 7, 8, 11, 14, 16, 17, 18, 21, 22, 23, 24, 25, 26, 27, 31};
        longint s = 0;
        longint m;
        m = longint'(w[30:0]);
        foreach (sh[i]) s = s + (m >> sh[i]);
        return {w[31], s[30:0]};
    endfunction

    // Transaction model: phase 0 waiting, 1 result being formed, 2 result offered.
    int          m_ptr = 0, m_phase = 0, m_id = 0, m_cnt = 0;
    logic [31:0] m_word = '0;
    int          w_cnt = 0, w_total = 0;
    bit          w_lit = 1'b0;

    always @(negedge clk) begin
        int          g;
        logic [3:0]  exp_rdy;
        if (!rst_n) begin
            m_ptr = 0; m_phase = 0; m_id = 0; m_cnt = 0; m_word = '0;
            w_cnt = 0; w_total = 0;
        end else begin
            g = -1;
            exp_rdy = '0;
            if (m_phase == 0) begin
                for (int k = 0; k < 4; k++)
                    if (g < 0 && bus.req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", busy, m_phase != 0);
            chk("out_valid", bus.out_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("out_data", bus.out_data, m_word);
                chk("out_id", bus.out_id, m_id);
            end
            chk("done_cnt", done_cnt, m_cnt);
            case (m_phase)
                0: if (g >= 0) begin
                    m_word  = model_scale(bus.req_data[32*g +: 32]);
                    m_id    = g;
                    m_ptr   = (g + 1) % 4;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (bus.out_ready) begin
                    m_phase = 0;
                    m_cnt   = (m_cnt + 1) % 65536;
                end
            endcase

            if (w_total == 8 && !w_lit) begin
                chk("wrap_literal", done_cnt_w, 3'd0);
                w_lit = 1'b1;
            end
            chk("done_cnt_w", done_cnt_w, w_cnt);
            if (bus_w.out_valid) begin
                w_cnt   = (w_cnt + 1) % 8;
                w_total = w_total + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
        end
    endtask

    task automatic xact(input int idx, input logic [31:0] word, input logic [31:0] ed, input int eid);
        bit ok;
        bus.req_valid = 4'(1 << idx);
        bus.req_data[32*idx +: 32] = word;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) ok = 1'b1;
        end
        if (!ok) chk("grant_timeout", 1, 0);
        cyc();
        bus.req_valid = '0;
        wait_out(ok);
        if (!ok) chk("out_timeout", 1, 0);
        chk("xact_data", bus.out_data, ed);
        chk("xact_id", bus.out_id, eid);
        cyc();
    endtask

    initial begin
        int          ids[$];
        int          grants[$];
        int          exp_ids[5] = '{0, 1, 2, 3, 0};
        logic [31:0] hd;
        logic [1:0]  hid;
        logic [15:0] cnt0;
        bit          ok;

        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        bus_w.req_valid = 4'b0001;
        bus_w.req_data  = '0;
        bus_w.out_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_req_ready", bus.req_ready, 4'b0000);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_id", bus.out_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done_cnt", done_cnt, 16'h0);
        chk("pin_scale_100", model_scale(32'h0000_0100), 32'h0000_00E7);
        chk("pin_scale_neg4", model_scale(32'h8000_0004), 32'h8000_0003);
        bus.req_valid = '0;
        rst_n = 1'b1;
        cyc();

        // Exact latency for a single request.
        bus.req_valid = 4'b0001;
        bus.req_data[31:0] = 32'h0000_0100;
        @(negedge clk);
        chk("t1_req_ready", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_calc_out_valid", bus.out_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("t1_out_valid", bus.out_valid, 1'b1);
        chk("t1_out_data", bus.out_data, 32'h0000_00E7);
        chk("t1_out_id", bus.out_id, 2'd0);
        cyc();

        xact(2, 32'h8000_0004, 32'h8000_0003, 2);
        xact(2, 32'h8000_0000, 32'h8000_0000, 2);

        // Four contending requesters from a fresh pointer.
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        bus.out_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 40 && ids.size() < 5; k++) begin
            @(negedge clk);
            if (|bus.req_ready) grants.push_back(k);
            if (bus.out_valid && bus.out_ready) ids.push_back(int'(bus.out_id));
        end
        cyc();
        bus.req_valid = '0;
        chk("t3_count", ids.size(), 5);
        foreach (ids[i]) if (i < 5) chk("t3_id_seq", ids[i], exp_ids[i]);
        for (int i = 1; i < grants.size() && i < 5; i++)
            chk("t3_grant_spacing", grants[i] - grants[i-1], 3);
        @(negedge clk);
        chk("t3_done_cnt", done_cnt, 16'd5);

        // Consumer stall: result frozen, no new grants.
        cyc();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
        wait_out(ok);
        if (!ok) chk("t4_timeout", 1, 0);
        hd  = bus.out_data;
        hid = bus.out_id;
        chk("t4_id", hid, 2'd1);
        chk("t4_data", hd, model_scale(bus.req_data[63:32]));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_hold_data", bus.out_data, hd);
            chk("t4_hold_id", bus.out_id, hid);
            chk("t4_hold_ready", bus.req_ready, 4'b0000);
        end
        cyc();
        cnt0 = done_cnt;
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t4_still_valid", bus.out_valid, 1'b1);
        cyc();
        @(negedge clk);
        chk("t4_released", bus.out_valid, 1'b0);
        chk("t4_single_hs", done_cnt, cnt0 + 16'd1);

        // Reset while a word is in flight.
        cyc();
        bus.req_valid = 4'b0100;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (bus.req_ready[2]) ok = 1'b1;
        end
        if (!ok) chk("t5_timeout", 1, 0);
        cyc();
        chk("t5_in_calc", busy, 1'b1);
        rst_n = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_done_cnt", done_cnt, 16'd0);
        chk("t5_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_lowest_grant", bus.req_ready, 4'b0010);
        cyc();
        bus.req_valid = '0;

        // Random traffic; the model checks every cycle.
        for (int k = 0; k < 600; k++) begin
            bus.req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 5))
                    0:       bus.req_data[32*i +: 32] = 32'h7FFF_FFFF;
                    1:       bus.req_data[32*i +: 32] = {1'b1, 31'($urandom_range(0, 255))};
                    default: bus.req_data[32*i +: 32] = $urandom;
                endcase
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (5) cyc();
        if (!w_lit) chk("wrap_never_reached", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
